// File: rtl/sum_sched_pkg.sv
// Shared types and helpers for the sum-engine scheduler and its arbiter.
package sum_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_W = 16;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sum_engine_scheduler_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter
    import sum_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_oh_o,
    output logic [ID_W-1:0]  gnt_idx_o,
    output logic             gnt_any_o
);

    int   idx;
    logic found;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_i) + k) % N_REQ;
            if (!found && (|(req_i & (N_REQ'(1) << idx)))) begin
                found     = 1'b1;
                gnt_oh_o  = N_REQ'(1) << idx;
                gnt_idx_o = ID_W'(idx);
            end
        end
    end

    assign gnt_any_o = found;

endmodule

// File: rtl/sum_engine_scheduler.sv
// Shares one active-low-go sum-until-zero engine among N_REQ requesters,
// streaming one packet at a time and returning the tagged total.
module sum_engine_scheduler
    import sum_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int W         = DEF_W,
    parameter int MAX_WORDS = 255
) (
    input  logic                   clk,
    input  logic                   reset_l,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*W-1:0]     req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [id_w(N_REQ)-1:0] rsp_id,
    output logic [W-1:0]           rsp_sum,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   eng_go_l,
    output logic [W-1:0]           eng_inA,
    input  logic                   eng_done,
    input  logic [W-1:0]           eng_sum
);

    localparam int ID_W  = id_w(N_REQ);
    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    state_t           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [W-1:0]     rsp_sum_q, rsp_sum_d;
    logic             rsp_err_q, rsp_err_d;

    logic [N_REQ-1:0] arb_oh;
    logic [ID_W-1:0]  arb_idx;
    logic             arb_any;
    logic [ID_W-1:0]  ptr_nxt;
    logic [W-1:0]     g_word;
    logic [W-1:0]     c_word;
    logic             c_valid;
    logic             cnt_full;
    logic             run_more;
    logic             run_force;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx),
        .gnt_any_o (arb_any)
    );

    assign g_word    = req_data[arb_idx*W +: W];
    assign c_word    = req_data[gnt_q*W +: W];
    assign c_valid   = req_valid[gnt_q];
    assign cnt_full  = (cnt_q == CNT_W'(MAX_WORDS));
    assign run_more  = c_valid && (c_word != '0) && !cnt_full;
    // A gap or an over-long packet is cut short by feeding the engine a zero.
    assign run_force = !c_valid || ((c_word != '0) && cnt_full);
    assign ptr_nxt   = (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    ptr_d = ptr_nxt;
                    gnt_d = arb_idx;
                    if (g_word != '0) begin
                        state_d = RUN;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        // Empty packet: answer directly, the engine is never started.
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = arb_idx;
                        rsp_sum_d   = '0;
                        rsp_err_d   = 1'b0;
                    end
                end
            end
            RUN: begin
                if (run_more) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = gnt_q;
                    rsp_sum_d   = eng_sum;
                    rsp_err_d   = run_force || !eng_done;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        eng_go_l  = 1'b1;
        eng_inA   = '0;
        busy      = (state_q == RUN);
        // Handshake outputs are held quiet while reset is asserted.
        if (reset_l) begin
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        req_ready = arb_oh;
                        if (g_word != '0) begin
                            eng_go_l = 1'b0;
                            eng_inA  = g_word;
                        end
                    end
                end
                RUN: begin
                    if (c_valid && ((c_word == '0) || !cnt_full)) begin
                        req_ready = N_REQ'(1) << gnt_q;
                        eng_inA   = c_word;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sum_engine_scheduler.sv
// Directed bench for sum_engine_scheduler with behavioural engine models;
// instance A uses default parameters, instance B uses MAX_WORDS=3.
module tb_sum_engine_scheduler;

    logic        clk = 1'b0;
    logic        reset_l;
    always #5 clk = ~clk;

    logic [3:0]  vA, vB, rdyA, rdyB;
    logic [63:0] dA, dB;
    logic        rvA, rvB, rerrA, rerrB, busyA, busyB, goA, goB, doneA, doneB;
    logic [1:0]  ridA, ridB;
    logic [15:0] rsumA, rsumB, inA_A, inA_B, sumA, sumB;
    logic        brkA;

    sum_engine_scheduler #(.N_REQ(4), .W(16), .MAX_WORDS(255)) dut_a (
        .clk(clk), .reset_l(reset_l), .req_valid(vA), .req_data(dA), .req_ready(rdyA),
        .rsp_valid(rvA), .rsp_id(ridA), .rsp_sum(rsumA), .rsp_err(rerrA), .busy(busyA),
        .eng_go_l(goA), .eng_inA(inA_A), .eng_done(doneA), .eng_sum(sumA)
    );

    sum_engine_scheduler #(.N_REQ(4), .W(16), .MAX_WORDS(3)) dut_b (
        .clk(clk), .reset_l(reset_l), .req_valid(vB), .req_data(dB), .req_ready(rdyB),
        .rsp_valid(rvB), .rsp_id(ridB), .rsp_sum(rsumB), .rsp_err(rerrB), .busy(busyB),
        .eng_go_l(goB), .eng_inA(inA_B), .eng_done(doneB), .eng_sum(sumB)
    );

    // Engine models: start on go_l low with the first word, add until a zero word.
    logic        runA, runB;
    logic [15:0] accA, accB;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            runA <= 1'b0;
            accA <= '0;
        end else if (!goA) begin
            runA <= 1'b1;
            accA <= inA_A;
        end else if (runA) begin
            if (inA_A == 16'h0) runA <= 1'b0;
            else accA <= accA + inA_A;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            runB <= 1'b0;
            accB <= '0;
        end else if (!goB) begin
            runB <= 1'b1;
            accB <= inA_B;
        end else if (runB) begin
            if (inA_B == 16'h0) runB <= 1'b0;
            else accB <= accB + inA_B;
        end
    end

    assign doneA = runA && (inA_A == 16'h0) && !brkA;
    assign sumA  = accA;
    assign doneB = runB && (inA_B == 16'h0);
    assign sumB  = accB;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        bit          dut;
        bit          brk;
        logic [3:0]  v;
        logic [63:0] d;
        logic [3:0]  rdy;
        logic        go;
        logic [15:0] ina;
        logic        bsy;
        logic        rv;
        logic [1:0]  rid;
        logic [15:0] rsum;
        logic        rerr;
    } vec_t;

    vec_t tab[$];

    function automatic logic [63:0] pk(input logic [15:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic void add(input bit dut, input bit brk, input logic [3:0] v,
                                input logic [63:0] d, input logic [3:0] rdy, input logic go,
                                input logic [15:0] ina, input logic bsy, input logic rv,
                                input logic [1:0] rid, input logic [15:0] rsum, input logic rerr);
        vec_t e;
        e.dut = dut; e.brk = brk; e.v = v; e.d = d; e.rdy = rdy; e.go = go; e.ina = ina;
        e.bsy = bsy; e.rv = rv; e.rid = rid; e.rsum = rsum; e.rerr = rerr;
        tab.push_back(e);
    endfunction

    task automatic apply(input int n, input vec_t e);
        logic [3:0]  rdy;
        logic        go, bsy, rv, rerr;
        logic [15:0] ina, rsum;
        logic [1:0]  rid;
        @(negedge clk);
        brkA = e.brk;
        if (e.dut == 1'b0) begin
            vA = e.v; dA = e.d; vB = '0; dB = '0;
        end else begin
            vB = e.v; dB = e.d; vA = '0; dA = '0;
        end
        #1;
        if (e.dut == 1'b0) begin
            rdy = rdyA; go = goA; ina = inA_A; bsy = busyA; rv = rvA; rid = ridA; rsum = rsumA; rerr = rerrA;
        end else begin
            rdy = rdyB; go = goB; ina = inA_B; bsy = busyB; rv = rvB; rid = ridB; rsum = rsumB; rerr = rerrB;
        end
        chk($sformatf("v%0d_ready", n), 32'(rdy), 32'(e.rdy));
        chk($sformatf("v%0d_go_l", n), 32'(go), 32'(e.go));
        chk($sformatf("v%0d_inA", n), 32'(ina), 32'(e.ina));
        chk($sformatf("v%0d_busy", n), 32'(bsy), 32'(e.bsy));
        chk($sformatf("v%0d_rsp_valid", n), 32'(rv), 32'(e.rv));
        if (e.rv) begin
            chk($sformatf("v%0d_rsp_id", n), 32'(rid), 32'(e.rid));
            chk($sformatf("v%0d_rsp_sum", n), 32'(rsum), 32'(e.rsum));
            chk($sformatf("v%0d_rsp_err", n), 32'(rerr), 32'(e.rerr));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] pw [4][6];
        int          len [4];
        int          pos [4];
        logic [15:0] exp_sum [5];
        logic [1:0]  exp_id [5];
        logic [3:0]  exp_rdy [5];
        logic [3:0]  snap;
        int          nr;
        int          split;

        // dut, brk, valid, data, ready, go_l, inA, busy, rsp_valid, rsp_id, rsp_sum, rsp_err
        add(0, 0, 4'b0001, pk(16'd3, 0, 0, 0),      4'b0001, 0, 16'd3,    0, 0, 0, 0, 0);
        add(0, 0, 4'b0001, pk(16'd5, 0, 0, 0),      4'b0001, 1, 16'd5,    1, 0, 0, 0, 0);
        add(0, 0, 4'b0001, pk(16'd7, 0, 0, 0),      4'b0001, 1, 16'd7,    1, 0, 0, 0, 0);
        add(0, 0, 4'b0001, pk(16'd0, 0, 0, 0),      4'b0001, 1, 16'd0,    1, 0, 0, 0, 0);
        add(0, 0, 4'b0000, 64'h0,                   4'b0000, 1, 16'd0,    0, 1, 0, 16'd15, 0);
        add(0, 0, 4'b0100, 64'h0,                   4'b0100, 1, 16'd0,    0, 0, 0, 0, 0);
        add(0, 0, 4'b0000, 64'h0,                   4'b0000, 1, 16'd0,    0, 1, 2, 16'd0, 0);
        add(0, 0, 4'b0010, pk(0, 16'hFFFF, 0, 0),   4'b0010, 0, 16'hFFFF, 0, 0, 0, 0, 0);
        add(0, 0, 4'b0010, pk(0, 16'h0002, 0, 0),   4'b0010, 1, 16'h0002, 1, 0, 0, 0, 0);
        add(0, 0, 4'b0010, pk(0, 16'h0000, 0, 0),   4'b0010, 1, 16'h0000, 1, 0, 0, 0, 0);
        add(0, 0, 4'b0000, 64'h0,                   4'b0000, 1, 16'd0,    0, 1, 1, 16'h0001, 0);
        add(0, 0, 4'b1000, pk(0, 0, 0, 16'd4),      4'b1000, 0, 16'd4,    0, 0, 0, 0, 0);
        add(0, 0, 4'b1000, pk(0, 0, 0, 16'd4),      4'b1000, 1, 16'd4,    1, 0, 0, 0, 0);
        add(0, 0, 4'b0000, pk(0, 0, 0, 16'd4),      4'b0000, 1, 16'd0,    1, 0, 0, 0, 0);
        add(0, 0, 4'b0000, 64'h0,                   4'b0000, 1, 16'd0,    0, 1, 3, 16'd8, 1);
        split = tab.size();
        // Engine fails to raise done on the terminator.
        add(0, 0, 4'b0001, pk(16'd5, 0, 0, 0),      4'b0001, 0, 16'd5,    0, 0, 0, 0, 0);
        add(0, 1, 4'b0001, pk(16'd0, 0, 0, 0),      4'b0001, 1, 16'd0,    1, 0, 0, 0, 0);
        add(0, 0, 4'b0000, 64'h0,                   4'b0000, 1, 16'd0,    0, 1, 0, 16'd5, 1);
        // MAX_WORDS=3: fourth word is refused and reopens as a new packet.
        add(1, 0, 4'b0001, pk(16'd1, 0, 0, 0),      4'b0001, 0, 16'd1,    0, 0, 0, 0, 0);
        add(1, 0, 4'b0001, pk(16'd1, 0, 0, 0),      4'b0001, 1, 16'd1,    1, 0, 0, 0, 0);
        add(1, 0, 4'b0001, pk(16'd1, 0, 0, 0),      4'b0001, 1, 16'd1,    1, 0, 0, 0, 0);
        add(1, 0, 4'b0001, pk(16'd1, 0, 0, 0),      4'b0000, 1, 16'd0,    1, 0, 0, 0, 0);
        add(1, 0, 4'b0001, pk(16'd1, 0, 0, 0),      4'b0001, 0, 16'd1,    0, 1, 0, 16'd3, 1);
        add(1, 0, 4'b0001, pk(16'd0, 0, 0, 0),      4'b0001, 1, 16'd0,    1, 0, 0, 0, 0);
        add(1, 0, 4'b0000, 64'h0,                   4'b0000, 1, 16'd0,    0, 1, 0, 16'd1, 0);

        // Reset with requests pending: handshake outputs must stay quiet.
        reset_l = 1'b0;
        brkA = 1'b0;
        vA = 4'hF; dA = {4{16'h0011}};
        vB = 4'hF; dB = {4{16'h0011}};
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready_a", 32'(rdyA), 32'h0);
        chk("rst_ready_b", 32'(rdyB), 32'h0);
        chk("rst_go_l", 32'(goA), 32'h1);
        chk("rst_inA", 32'(inA_A), 32'h0);
        chk("rst_busy", 32'(busyA), 32'h0);
        chk("rst_rsp_valid", 32'(rvA), 32'h0);
        chk("rst_rsp_id", 32'(ridA), 32'h0);
        chk("rst_rsp_sum", 32'(rsumA), 32'h0);
        chk("rst_rsp_err", 32'(rerrA), 32'h0);
        vA = '0; dA = '0; vB = '0; dB = '0;
        @(negedge clk);
        reset_l = 1'b1;

        for (int i = 0; i < split; i++) apply(i, tab[i]);

        // All four channels contend with 2-word packets; ch0 has a second packet queued.
        pw[0][0] = 16'd1; pw[0][1] = 16'd2; pw[0][2] = 16'd0;
        pw[0][3] = 16'd9; pw[0][4] = 16'd9; pw[0][5] = 16'd0; len[0] = 6;
        pw[1][0] = 16'd3; pw[1][1] = 16'd4; pw[1][2] = 16'd0; len[1] = 3;
        pw[2][0] = 16'd5; pw[2][1] = 16'd6; pw[2][2] = 16'd0; len[2] = 3;
        pw[3][0] = 16'd7; pw[3][1] = 16'd8; pw[3][2] = 16'd0; len[3] = 3;
        for (int c = 0; c < 4; c++) pos[c] = 0;
        exp_id[0] = 2'd0; exp_sum[0] = 16'd3;  exp_rdy[0] = 4'b0010;
        exp_id[1] = 2'd1; exp_sum[1] = 16'd7;  exp_rdy[1] = 4'b0100;
        exp_id[2] = 2'd2; exp_sum[2] = 16'd11; exp_rdy[2] = 4'b1000;
        exp_id[3] = 2'd3; exp_sum[3] = 16'd15; exp_rdy[3] = 4'b0001;
        exp_id[4] = 2'd0; exp_sum[4] = 16'd18; exp_rdy[4] = 4'b0000;
        nr = 0;
        for (int cyc = 0; cyc < 40 && nr < 5; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                vA[2'(c)]       = (pos[c] < len[c]);
                dA[c*16 +: 16]  = (pos[c] < len[c]) ? pw[c][pos[c]] : 16'h0;
            end
            #1;
            snap = rdyA;
            if (rvA) begin
                chk($sformatf("rr%0d_id", nr), 32'(ridA), 32'(exp_id[nr]));
                chk($sformatf("rr%0d_sum", nr), 32'(rsumA), 32'(exp_sum[nr]));
                chk($sformatf("rr%0d_err", nr), 32'(rerrA), 32'h0);
                chk($sformatf("rr%0d_next_grant", nr), 32'(rdyA), 32'(exp_rdy[nr]));
                nr++;
            end
            @(posedge clk);
            for (int c = 0; c < 4; c++) if (snap[2'(c)]) pos[c]++;
        end
        chk("rr_rsp_count", 32'(nr), 32'd5);
        @(negedge clk);
        vA = '0; dA = '0;

        for (int i = split; i < tab.size(); i++) apply(i, tab[i]);
        @(negedge clk);
        vA = '0; dA = '0; vB = '0; dB = '0; brkA = 1'b0;

        // Reset in the middle of a packet drops it; arbitration restarts at ch0.
        @(negedge clk);
        vA = 4'b0100; dA = pk(0, 0, 16'd5, 0);
        #1;
        chk("mid_rst_grant", 32'(rdyA), 32'b0100);
        @(negedge clk);
        dA = pk(0, 0, 16'd6, 0);
        #1;
        chk("mid_rst_busy", 32'(busyA), 32'h1);
        reset_l = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(rdyA), 32'h0);
        chk("mid_rst_go_l", 32'(goA), 32'h1);
        chk("mid_rst_inA", 32'(inA_A), 32'h0);
        chk("mid_rst_busy_low", 32'(busyA), 32'h0);
        chk("mid_rst_rsp_valid", 32'(rvA), 32'h0);
        chk("mid_rst_rsp_sum", 32'(rsumA), 32'h0);
        chk("mid_rst_rsp_err", 32'(rerrA), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset_l = 1'b1;
        vA = 4'b0101; dA = pk(16'd7, 0, 16'd6, 0);
        #1;
        chk("post_rst_grant", 32'(rdyA), 32'b0001);
        chk("post_rst_go_l", 32'(goA), 32'h0);
        chk("post_rst_inA", 32'(inA_A), 32'd7);
        @(negedge clk);
        dA = pk(16'd0, 0, 16'd6, 0);
        #1;
        chk("post_rst_no_rsp", 32'(rvA), 32'h0);
        chk("post_rst_term", 32'(rdyA), 32'b0001);
        @(negedge clk);
        vA = 4'b0100;
        #1;
        chk("post_rst_rsp_valid", 32'(rvA), 32'h1);
        chk("post_rst_rsp_id", 32'(ridA), 32'h0);
        chk("post_rst_rsp_sum", 32'(rsumA), 32'd7);
        chk("post_rst_ch2_grant", 32'(rdyA), 32'b0100);
        @(negedge clk);
        vA = '0; dA = '0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
